// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 sizes, FSM states, byte-strobe bases.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] WSTRB_B = 8'h01;
  localparam logic [7:0] WSTRB_H = 8'h03;
  localparam logic [7:0] WSTRB_W = 8'h0F;
  localparam logic [7:0] WSTRB_D = 8'hFF;

  typedef enum logic {MEM_IDLE, MEM_WAIT_RSP} mem_state_e;

  // Byte offset with the bits below the access size cleared (size = log2 bytes).
  function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return off;
      2'd1:    return {off[2:1], 1'b0};
      2'd2:    return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    return align_off(size, off) != off;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load formatter: picks the addressed lane out of the aligned doubleword and sign/zero extends it.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_H:    data_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_W:    data_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_D:    data_o = sh;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_WU:   data_o = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: one outstanding dmem access, load formatting, MEM/WB registers.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip memory and raise MisalignW.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemToRegM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALU_ResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [4:0]        RD_M,
  output logic              StallM,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              MisalignW,
`endif
  output logic              ValidW,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [XLEN-1:0]   ALU_ResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [4:0]        RD_W
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rdata;
    logic [4:0]      rd;
  } wb_t;

  mem_state_e      state_q, state_d;
  wb_t             wb_q, wb_d;
  logic [1:0]      size;
  logic [2:0]      off;
  logic [7:0]      strb_base;
  logic [XLEN-1:0] load_data;
  logic            memop, trap_hit, req_vld, stall, complete, load_done;

  assign size  = Funct3M[1:0];
  assign off   = align_off(size, ALU_ResultM[2:0]);
  assign memop = ValidM & (MemReadM | MemWriteM);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = memop & misaligned(size, ALU_ResultM[2:0]);
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    strb_base = WSTRB_D;
    case (size)
      2'd0:    strb_base = WSTRB_B;
      2'd1:    strb_base = WSTRB_H;
      2'd2:    strb_base = WSTRB_W;
      default: strb_base = WSTRB_D;
    endcase
  end

  // Read wins when both MemReadM and MemWriteM are set.
  assign dmem_we        = ~MemReadM;
  assign dmem_addr      = {ALU_ResultM[ADDR_W-1:3], 3'b000};
  assign dmem_wdata     = WriteDataM << {off, 3'b000};
  assign dmem_wstrb     = strb_base << off;
  assign dmem_req_valid = req_vld & rst_n;
  assign StallM         = stall;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i (Funct3M),
    .off_i    (off),
    .rdata_i  (dmem_rdata),
    .data_o   (load_data)
  );

  always_comb begin
    state_d   = state_q;
    req_vld   = 1'b0;
    stall     = 1'b0;
    complete  = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (memop && !trap_hit) begin
          req_vld = 1'b1;
          if (!dmem_req_ready) begin
            stall = 1'b1;
          end else if (MemReadM) begin
            stall   = 1'b1;
            state_d = MEM_WAIT_RSP;
          end else begin
            complete = 1'b1;
          end
        end else begin
          complete = 1'b1;
        end
      end
      MEM_WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          complete  = 1'b1;
          load_done = 1'b1;
          state_d   = MEM_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Anything other than a completing valid instruction is a bubble; data fields hold.
  always_comb begin
    wb_d          = wb_q;
    wb_d.valid    = 1'b0;
    wb_d.regwrite = 1'b0;
    if (complete && ValidM) begin
      wb_d.valid    = 1'b1;
      wb_d.regwrite = RegWriteM & ~trap_hit;
      wb_d.memtoreg = MemToRegM;
      wb_d.alu      = ALU_ResultM;
      wb_d.rd       = RD_M;
      if (load_done) wb_d.rdata = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign misalign_d = complete & ValidM & trap_hit;
  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign MisalignW = misalign_q;
`endif

  assign ValidW      = wb_q.valid;
  assign RegWriteW   = wb_q.regwrite;
  assign MemToRegW   = wb_q.memtoreg;
  assign ALU_ResultW = wb_q.alu;
  assign ReadDataW   = wb_q.rdata;
  assign RD_W        = wb_q.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected W results queued at issue, popped when ValidW appears.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ValidM = 0, RegWriteM = 0, MemToRegM = 0, MemReadM = 0, MemWriteM = 0;
  logic [2:0]  Funct3M = '0;
  logic [63:0] ALU_ResultM = '0, WriteDataM = '0, dmem_rdata = '0;
  logic [4:0]  RD_M = '0;
  logic        StallM, dmem_req_valid, dmem_we;
  logic        dmem_req_ready = 0, dmem_rsp_valid = 0;
  logic [63:0] dmem_addr, dmem_wdata, ALU_ResultW, ReadDataW;
  logic [7:0]  dmem_wstrb;
  logic        ValidW, RegWriteW, MemToRegW;
  logic [4:0]  RD_W;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignW;
`endif

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .RD_M(RD_M), .StallM(StallM), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .MisalignW(MisalignW),
`endif
    .ValidW(ValidW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .RD_W(RD_W)
  );

  typedef struct {
    logic        regwrite, memtoreg, misal;
    logic [63:0] alu, rdata;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0, n_err = 0;
  logic [63:0] rd_hold = '0;
  logic [63:0] last_addr = '0, last_wdata = '0;
  logic [7:0]  last_strb = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_nb(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [2:0] a);
    return int'(a) / m_nb(f3) * m_nb(f3);
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [2:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (int'(a) % m_nb(f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [2:0] a);
    logic [7:0] s = '0;
    for (int i = 0; i < m_nb(f3); i++) s[m_off(f3, a) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [2:0] a, input logic [63:0] rd);
    logic [63:0] v = '0;
    int nb = m_nb(f3);
    int o  = m_off(f3, a);
    if (f3 == 3'b111) return '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(o+i) +: 8];
    if (!f3[2] && nb < 8 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  // Drive one instruction, play memory with the given ready/response latencies, hold until StallM drops.
  task automatic run(input logic rw, input logic m2r, input logic rd_en, input logic wr_en,
                     input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] wd,
                     input logic [4:0] rd, input logic [63:0] rdata, input int rlat, input int llat);
    exp_t e;
    logic mem = rd_en | wr_en;
    logic mis = mem && m_mis(f3, alu[2:0]);
    int   exp_st, cyc = 0, acc = -1, stalls = 0;
    bit   done = 0;
    ValidM = 1; RegWriteM = rw; MemToRegM = m2r; MemReadM = rd_en; MemWriteM = wr_en;
    Funct3M = f3; ALU_ResultM = alu; WriteDataM = wd; RD_M = rd;
    if (rd_en && !mis) rd_hold = m_load(f3, alu[2:0], rdata);
    e.regwrite = rw & !mis; e.memtoreg = m2r; e.misal = mis;
    e.alu = alu; e.rdata = rd_hold; e.rd = rd;
    sb.push_back(e);
    exp_st = (!mem || mis) ? 0 : rlat + (rd_en ? llat : 0);
    while (!done && cyc < 64) begin
      dmem_req_ready = (acc < 0 && cyc >= rlat);
      dmem_rsp_valid = (acc >= 0 && cyc - acc == llat);
      dmem_rdata     = rdata;
      #1;
      if (dmem_req_valid) begin
        if (mis || acc >= 0 || !mem) chk("req_spurious", 64'(dmem_req_valid), 64'd0);
        else begin
          chk("req_addr", dmem_addr, {alu[63:3], 3'b000});
          chk("req_we", 64'(dmem_we), 64'(!rd_en));
          if (!rd_en) begin
            chk("req_wstrb", 64'(dmem_wstrb), 64'(m_strb(f3, alu[2:0])));
            chk("req_wdata", dmem_wdata, wd << (8 * m_off(f3, alu[2:0])));
          end
          last_addr = dmem_addr; last_strb = dmem_wstrb; last_wdata = dmem_wdata;
          if (dmem_req_ready) acc = cyc;
        end
      end else if (mem && !mis && acc < 0) begin
        chk("req_missing", 64'(dmem_req_valid), 64'd1);
      end
      if (StallM) stalls++;
      else        done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) chk("timeout", 64'd0, 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_st));
    ValidM = 0; dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  always @(negedge clk) begin
    if (ValidW) begin
      if (sb.size() == 0) chk("unexpected_validw", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("RegWriteW", 64'(RegWriteW), 64'(mon_e.regwrite));
        chk("MemToRegW", 64'(MemToRegW), 64'(mon_e.memtoreg));
        chk("ALU_ResultW", ALU_ResultW, mon_e.alu);
        chk("ReadDataW", ReadDataW, mon_e.rdata);
        chk("RD_W", 64'(RD_W), 64'(mon_e.rd));
`ifdef MEM_MISALIGN_TRAP_EN
        chk("MisalignW", 64'(MisalignW), 64'(mon_e.misal));
`endif
      end
    end else if (RegWriteW) begin
      chk("bubble_regwrite", 64'(RegWriteW), 64'd0);
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [63:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ValidW", 64'(ValidW), 64'd0);
    chk("rst_RegWriteW", 64'(RegWriteW), 64'd0);
    chk("rst_ALU_ResultW", ALU_ResultW, 64'd0);
    chk("rst_ReadDataW", ReadDataW, 64'd0);
    chk("rst_RD_W", 64'(RD_W), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // ALU op
    run(1, 0, 0, 0, F3_D, 64'h1234, 64'd0, 5'd5, 64'd0, 0, 0);
    chk("alu_ValidW", 64'(ValidW), 64'd1);
    chk("alu_ALU_ResultW", ALU_ResultW, 64'h1234);
    chk("alu_RD_W", 64'(RD_W), 64'd5);

    // SB at 0x1003
    run(0, 0, 0, 1, F3_B, 64'h1003, 64'hAB, 5'd0, 64'd0, 0, 0);
    chk("sb_wstrb", 64'(last_strb), 64'h08);
    chk("sb_wdata", last_wdata, 64'hAB00_0000);
    chk("sb_addr", last_addr, 64'h1000);

    // LB with ready low 2 cycles and response 3 cycles after accept
    run(1, 1, 1, 0, F3_B, 64'h2005, 64'd0, 5'd7, 64'h0000_80FF_0000_0000, 2, 3);
    chk("lb_data", ReadDataW, 64'hFFFF_FFFF_FFFF_FF80);

    run(1, 1, 1, 0, F3_WU, 64'h2004, 64'd0, 5'd8, 64'h8000_0001_1234_5678, 0, 1);
    chk("lwu_data", ReadDataW, 64'h0000_0000_8000_0001);
    run(1, 1, 1, 0, F3_W, 64'h2004, 64'd0, 5'd8, 64'h8000_0001_1234_5678, 0, 1);
    chk("lw_data", ReadDataW, 64'hFFFF_FFFF_8000_0001);

    run(1, 1, 1, 0, 3'b111, 64'h2000, 64'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    chk("f3_111_data", ReadDataW, 64'd0);

    // Both MemRead and MemWrite: behaves as a load
    run(1, 1, 1, 1, F3_D, 64'h2008, 64'h55, 5'd10, 64'h0123_4567_89AB_CDEF, 1, 2);
    chk("rdwr_data", ReadDataW, 64'h0123_4567_89AB_CDEF);

    // Misaligned LW at 0x3002
    run(1, 1, 1, 0, F3_W, 64'h3002, 64'd0, 5'd11, 64'h1111_2222_3333_4444, 0, 1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_MisalignW", 64'(MisalignW), 64'd1);
    chk("mis_RegWriteW", 64'(RegWriteW), 64'd0);
`else
    chk("mis_addr", last_addr, 64'h3000);
    chk("mis_data", ReadDataW, 64'h0000_0000_3333_4444);
`endif

    // Mixed back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      a = {32'd0, $urandom} & 64'hFFFF_FFFF;
      case ($urandom_range(0, 2))
        0: begin
          f3 = 3'($urandom_range(0, 6));
          run(1, 1, 1, 0, f3, a, 64'd0, 5'($urandom), {$urandom, $urandom},
              $urandom_range(0, 2), $urandom_range(1, 3));
        end
        1: begin
          f3 = 3'($urandom_range(0, 3));
          run(0, 0, 0, 1, f3, a, {$urandom, $urandom}, 5'($urandom), 64'd0,
              $urandom_range(0, 2), 1);
        end
        default: run(1, 0, 0, 0, F3_D, a, 64'd0, 5'($urandom), 64'd0, 0, 0);
      endcase
    end

    // Reset while waiting for a load response; a later response must be ignored
    ValidM = 1; RegWriteM = 1; MemToRegM = 1; MemReadM = 1; MemWriteM = 0;
    Funct3M = F3_D; ALU_ResultM = 64'h40; RD_M = 5'd9; dmem_req_ready = 1;
    @(posedge clk); #1;
    dmem_req_ready = 0;
    chk("wait_stall", 64'(StallM), 64'd1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; ValidM = 0; MemReadM = 0; RegWriteM = 0; MemToRegM = 0;
    dmem_rsp_valid = 1; dmem_rdata = '1;
    @(posedge clk); #1;
    dmem_rsp_valid = 0;
    rd_hold = '0;
    chk("abort_ValidW", 64'(ValidW), 64'd0);
    chk("abort_ReadDataW", ReadDataW, 64'd0);
    chk("abort_ALU_ResultW", ALU_ResultW, 64'd0);
    chk("abort_RD_W", 64'(RD_W), 64'd0);
    chk("abort_MemToRegW", 64'(MemToRegW), 64'd0);
    chk("abort_StallM", 64'(StallM), 64'd0);
    chk("abort_req_valid", 64'(dmem_req_valid), 64'd0);

    run(1, 0, 0, 0, F3_D, 64'h77, 64'd0, 5'd3, 64'd0, 0, 0);
    chk("post_abort_alu", ALU_ResultW, 64'h77);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
